usb_pio_in_irq: RTL
===================

# usb_pio_in_irq

Parametrised Avalon-MM input PIO for the USB/MIDI host side, replacing the single-bit, poll-only GPX status port. It samples WIDTH asynchronous status/interrupt pins (MAX3421E GPX/INT, MIDI-detect and similar) through a synchroniser and optional per-bit debouncer. It latches qualifying edges in a sticky edge-capture register and raises a level IRQ to the Nios II. The CPU no longer has to poll these pins.

## Interface
- WIDTH, 8, number of input bits (1..32)
- SYNC_STAGES, 2, synchroniser flops per bit (>=2)
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before a change is accepted; 0 = bypass
- EDGE_TYPE, 0, 0 = rising, 1 = falling, 2 = any edge
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  Avalon word address
- chipselect  in  1  slave select
- write  in  1  write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  WIDTH  asynchronous input pins
- irq  out  1  level interrupt, active-high

## Operation
- Register map:
  - 0 DATA (RO): filtered input value.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK (RW): bits [WIDTH-1:0].
  - 3 EDGE_CAPTURE: write-1-to-clear.
- Bits above WIDTH read 0. Writes to addresses 0 and 1 are ignored.
- Synchroniser: SYNC_STAGES-deep flop chain per bit produces sync_out.
- Debounce (DEBOUNCE_CYCLES = D > 0), per bit:
  - State: stable value and counter, counter width $clog2(D+1).
  - sync_out == stable: counter <= 0.
  - sync_out != stable and counter == D-1: stable <= sync_out, counter <= 0.
  - Otherwise: counter increments.
  - A glitch shorter than D cycles never reaches filt.
- With D = 0, filt = sync_out.
- Edge detect:
  - prev <= filt every cycle.
  - rise = filt & ~prev; fall = ~filt & prev; selection per EDGE_TYPE.
- EDGE_CAPTURE: next = (cur & ~clr) | edge, where clr = writedata when writing address 3.
  - Simultaneous clear and new edge on the same bit: set wins, so no event is lost.
- irq = |(EDGE_CAPTURE & IRQ_MASK), a combinational OR of flop outputs.
  - Unmasking an already-captured bit asserts irq immediately.
- readdata <= mux(address) every cycle, independent of the read strobe.

## Timing
- Reset values (all 0): readdata, irq, IRQ_MASK, EDGE_CAPTURE, synchroniser flops, stable, prev, counters.
  - An input held high through reset release therefore records a rising edge after the synchronisation latency. This is intended: the GPX INT-pending state is not lost.
- Input latency: in_port changes before clk edge E0 → sync_out valid after edge E0+SYNC_STAGES-1 → filt after edge E0+SYNC_STAGES-1+D.
  - EDGE_CAPTURE bit set and irq asserted after edge E0+SYNC_STAGES+D.
  - Read with address 0 at that cycle shows the new value on the following edge.
- Read latency is 1 cycle: address presented at edge N, readdata valid after edge N+1.
- A write takes effect at the edge where write & chipselect are sampled. irq reflects it in the same following cycle.
- Reset mid-debounce discards counters; no partial edge survives.

## Structure
- Package pio_pkg holds:
  - address constants ADDR_DATA = 0, ADDR_RSVD = 1, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3;
  - edge_type_e enum (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- Sub-module pio_debounce: one bit, parameter D, containing the synchroniser chain, counter and stable flop. Generated WIDTH times.
- Edge logic, registers and bus mux stay in the top level.

## Test plan
- Reset with in_port = 0x00, then read addresses 0–3 → all readdata 0, irq 0.
- WIDTH = 8, SYNC = 2, D = 0, EDGE = rise:
  - in_port 0x00 → 0x05 before E0 → EDGE_CAPTURE = 0x05 after E0+2.
  - Write IRQ_MASK = 0x04 → irq 1.
  - Write 0x04 to address 3 → irq 0 next cycle, capture = 0x01.
- D = 4: 3-cycle pulse on bit 0 → DATA stays 0, no capture. 4-cycle pulse → DATA bit 0 = 1 after E0+2+4, capture set.
- New rising edge on bit 1 in the same cycle as a write-1 clear of bit 1 → bit 1 remains set.
- EDGE = any, toggle bit 7 twice → capture set after the first edge. Clear, then the second edge sets it again. DATA tracks the pin.
- Assert reset_n low mid-debounce with irq active → irq, IRQ_MASK and EDGE_CAPTURE return 0 asynchronously.

Source files
------------

// File: rtl/usb_pio_in_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module : pio_pkg
// Desc   : Register addresses and edge-type encoding for usb_pio_in_irq.
// Rev    : 1.0
// ============================================================================
package pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_type_e;

endpackage
`default_nettype wire

// File: rtl/usb_pio_in_irq_if.sv
`default_nettype none
// ============================================================================
// Module : usb_pio_in_irq_if
// Desc   : Avalon-MM slave bus, input pins and IRQ of the input PIO.
// Rev    : 1.0
// ============================================================================
interface usb_pio_in_irq_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       address;
   logic             chipselect;
   logic             write;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [WIDTH-1:0] in_port;
   logic             irq;

   modport master (
      output address, chipselect, write, writedata, in_port,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write, writedata, in_port,
      output readdata, irq
   );
endinterface
`default_nettype wire

// File: rtl/usb_pio_in_irq_debounce.sv
`default_nettype none
// ============================================================================
// Module : pio_debounce
// Desc   : One input bit: synchroniser chain plus optional stability filter.
// Rev    : 1.0
// ============================================================================
module pio_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int D           = 0
) (
   input  wire logic clk,
   input  wire logic reset_n,
   input  wire logic in_i,
   output logic      filt_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   generate
      if (D == 0) begin : g_bypass
         assign filt_o = sync_out;
      end else begin : g_filter
         localparam int            CW   = $clog2(D + 1);
         localparam logic [CW-1:0] LAST = CW'(D - 1);

         logic [CW-1:0] cnt_q, cnt_d;
         logic          stable_q, stable_d;

         // Counter tracks consecutive cycles the pin disagrees with the accepted value
         always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            if (sync_out != stable_q) begin
               if (cnt_q == LAST) stable_d = sync_out;
               else               cnt_d    = cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q    <= '0;
               stable_q <= 1'b0;
            end else begin
               cnt_q    <= cnt_d;
               stable_q <= stable_d;
            end
         end

         assign filt_o = stable_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/usb_pio_in_irq.sv
`default_nettype none
// ============================================================================
// Module : usb_pio_in_irq
// Desc   : Avalon-MM input PIO with sticky edge capture and level IRQ.
// Rev    : 1.0
// ============================================================================
module usb_pio_in_irq
   import pio_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_TYPE       = 0
) (
   input  wire logic        clk,
   input  wire logic        reset_n,
   usb_pio_in_irq_if.slave  avs
);

   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] rise, fall, edge_ev, clr;
   logic [31:0]      rdata_q, rdata_d;
   logic             wr_en;
   logic             unused_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         pio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .D           (DEBOUNCE_CYCLES)
         ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .in_i    (avs.in_port[gi]),
            .filt_o  (filt[gi])
         );
      end
   endgenerate

   assign wr_en        = avs.chipselect & avs.write;
   assign unused_wdata = ^avs.writedata;

   always_comb begin
      rise = filt & ~prev_q;
      fall = ~filt & prev_q;
      if (EDGE_TYPE == int'(EDGE_RISE))      edge_ev = rise;
      else if (EDGE_TYPE == int'(EDGE_FALL)) edge_ev = fall;
      else                                   edge_ev = rise | fall;
   end

   // A new edge overrides a same-cycle write-1-to-clear so no event is dropped
   always_comb begin
      clr    = '0;
      mask_d = mask_q;
      if (wr_en && avs.address == ADDR_EDGECAP) clr    = avs.writedata[WIDTH-1:0];
      if (wr_en && avs.address == ADDR_IRQMASK) mask_d = avs.writedata[WIDTH-1:0];
      cap_d = (cap_q & ~clr) | edge_ev;
   end

   always_comb begin
      rdata_d = '0;
      case (avs.address)
         ADDR_DATA:    rdata_d[WIDTH-1:0] = filt;
         ADDR_IRQMASK: rdata_d[WIDTH-1:0] = mask_q;
         ADDR_EDGECAP: rdata_d[WIDTH-1:0] = cap_q;
         default:      rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q  <= '0;
         mask_q  <= '0;
         cap_q   <= '0;
         rdata_q <= '0;
      end else begin
         prev_q  <= filt;
         mask_q  <= mask_d;
         cap_q   <= cap_d;
         rdata_q <= rdata_d;
      end
   end

   assign avs.readdata = rdata_q;
   assign avs.irq      = |(cap_q & mask_q);

endmodule
`default_nettype wire
